div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
Multi-cycle 32-bit divider for DIV/DIVU. It is the inverse companion to the single-cycle multiply path in the execute stage.
- Quotient goes to LO, remainder goes to HI.
- Uses a radix-2 restoring algorithm, one quotient bit per cycle.
- Sits beside the ALU in EX. Stalls the pipeline while busy and can be annulled by an exception flush.

Parameters:
WIDTH, 32, operand, quotient and remainder width. Only 32 is supported by the core.

Ports:
clk  in  1  core clock, rising edge
resetn  in  1  asynchronous reset, active low
start_i  in  1  request a division. Sampled only in IDLE or DONE.
signed_i  in  1  1 = DIV (two's complement), 0 = DIVU. Sampled with start_i.
dividend_i  in  WIDTH  rs operand. Sampled with start_i.
divisor_i  in  WIDTH  rt operand. Sampled with start_i.
annul_i  in  1  flush; aborts any operation in progress
busy_o  out  1  stall request to pipeline control
ready_o  out  1  one-cycle pulse: results valid this cycle
quotient_o  out  WIDTH  to LO write path
remainder_o  out  WIDTH  to HI write path

Behaviour:
- States: IDLE, BUSY, DONE. A 5-bit counter cnt is used in BUSY.
- Reset (async, resetn=0):
  - state=IDLE, cnt=0, ready_o=0.
  - quotient_o=0, remainder_o=0.
  - All internal partial remainder and quotient registers = 0.
- Accept: start_i=1 && annul_i=0 && state in {IDLE, DONE}.
  - Latch |dividend| and |divisor|. Magnitudes are used only when signed_i=1; otherwise raw values.
  - Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31] (both forced 0 when signed_i=0).
  - Clear partial remainder. cnt=0. Go to BUSY.
- BUSY, each cycle:
  - rem = {rem[30:0], dvd[31]}, dvd <<= 1.
  - If rem >= dvs: rem -= dvs, shift in quotient bit 1; else shift in 0.
  - cnt++. After the iteration with cnt=31, go to DONE.
- DONE (exactly one cycle):
  - ready_o=1.
  - quotient_o = sign_q ? -q : q.
  - remainder_o = sign_r ? -rem : rem.
  - Outputs are registered at DONE entry and hold until the next DONE. They do not change on annul or on a new start.
  - Then go to IDLE, or to BUSY if a new accept occurs in DONE.
- Latency: accept in cycle N gives BUSY in N+1..N+32 and ready_o=1 in N+33.
- busy_o = (state==BUSY) | (state!=BUSY & start_i & ~annul_i). It is combinational so the accept cycle also stalls. It is 0 in the DONE cycle unless a new accept occurs.
- annul_i=1 in BUSY: go to IDLE next cycle, no ready_o, outputs unchanged.
- annul_i=1 with start_i: start is ignored.
- annul_i in DONE: ready_o still pulses. The consumer qualifies the HI/LO write itself.
- start_i in BUSY: ignored. The pipeline holds the request because busy_o=1.
- Arithmetic:
  - Partial remainder is 33 bits wide for the compare/subtract.
  - Negation is two's complement, modulo 2^32.
  - 0x80000000 / 0xFFFFFFFF signed gives q=0x80000000, r=0. No trap.
- Divisor zero (architecturally UNPREDICTABLE, but defined here): the algorithm yields q_mag=0xFFFFFFFF, rem_mag=|dividend|.
  - Unsigned: quotient_o=0xFFFFFFFF, remainder_o=dividend.
  - Signed: quotient_o = dividend[31] ? 0x00000001 : 0xFFFFFFFF, remainder_o=dividend.
  - No overflow or exception output.

Optional Feature:
DIV_ZERO_FAST_EN
- Defined: divisor_i==0 at accept goes directly to DONE next cycle (ready_o in N+1). Results are bit-identical to the divisor-zero values above. Nonzero divisors are unchanged.
- Undefined: divisor zero runs the full 32 iterations (ready_o in N+33).

Decomposition:
- Shared package div_pkg:
  - State enum div_state_t {IDLE, BUSY, DONE}.
  - DIV_ITERS=32.
  - DIVZERO_Q_UNSIGNED=32'hFFFFFFFF.
- One sub-module div_step: a combinational single restoring iteration, (rem, dvd, dvs) -> (rem_next, dvd_next, q_bit). The FSM, counter and sign fix-up remain in div_unit.

Test Plan:
- DIVU 100/7, start at cycle 0 -> ready_o at cycle 33, quotient_o=14, remainder_o=2; busy_o high cycles 0..32.
- DIV -7/2 (0xFFFFFFF9, 2) -> quotient_o=0xFFFFFFFD (-3), remainder_o=0xFFFFFFFF (-1); DIV 7/-2 -> q=-3, r=1.
- DIV 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0; DIVU same operands -> q=0, r=0x80000000.
- Divisor 0: DIVU 5/0 -> q=0xFFFFFFFF, r=5; DIV 0xFFFFFFFB/0 -> q=1, r=0xFFFFFFFB; ready at N+33 without the macro, N+1 with DIV_ZERO_FAST_EN.
- Annul at BUSY cycle 10 -> no ready_o, outputs keep the previous result. A new start two cycles later completes normally. Also: start with annul_i=1 in the same cycle -> stays IDLE.
- Back-to-back: new start in the DONE cycle -> second ready_o exactly 33 cycles later. Also: resetn low mid-BUSY -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the multi-cycle DIV/DIVU unit.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int          DIV_ITERS          = 32;
    localparam logic [31:0] DIVZERO_Q_UNSIGNED = 32'hFFFF_FFFF;

    // Two's complement magnitude, applied only for signed operations.
    function automatic logic [31:0] mag_if(input logic [31:0] v, input logic en);
        return (en && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration; the quotient bit is shifted into
// the vacated LSB of the dividend register.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] dvd_o,
    output logic             q_bit_o
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        shifted = {rem_i, dvd_i[WIDTH-1]};
        diff    = shifted[WIDTH:0] - {1'b0, dvs_i};
        q_bit_o = (shifted >= {2'b00, dvs_i});
        rem_o   = q_bit_o ? diff : shifted[WIDTH:0];
        dvd_o   = {dvd_i[WIDTH-2:0], q_bit_o};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU (quotient -> LO, remainder -> HI).
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes in one cycle.
module div_unit
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             annul_i,
    output logic             busy_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

    div_state_t       state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sign_q_q, sign_q_d;
    logic             sign_r_q, sign_r_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] dvd_next;
    logic             q_bit;
    logic             accept;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i   (rem_q),
        .dvd_i   (dvd_q),
        .dvs_i   (dvs_q),
        .rem_o   (rem_next),
        .dvd_o   (dvd_next),
        .q_bit_o (q_bit)
    );

    assign accept = start_i & ~annul_i & (state_q != BUSY);

    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        sign_q_d    = sign_q_q;
        sign_r_d    = sign_r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        q_final     = {dvd_q[WIDTH-2:0], q_bit};
        r_final     = rem_next[WIDTH-1:0];

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    dvd_d    = mag_if(dividend_i, signed_i);
                    dvs_d    = mag_if(divisor_i, signed_i);
                    sign_q_d = signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                    sign_r_d = signed_i & dividend_i[WIDTH-1];
                    rem_d    = '0;
                    cnt_d    = '0;
                    state_d  = BUSY;
`ifdef DIV_ZERO_FAST_EN
                    // Same values the full iteration would produce for a zero divisor.
                    if (divisor_i == '0) begin
                        state_d     = DONE;
                        quotient_d  = (signed_i && dividend_i[WIDTH-1]) ?
                                      WIDTH'(1) : DIVZERO_Q_UNSIGNED;
                        remainder_d = dividend_i;
                    end
`endif
                end
            end
            BUSY: begin
                if (annul_i) begin
                    state_d = IDLE;
                end else begin
                    rem_d = rem_next;
                    dvd_d = dvd_next;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_CNT) begin
                        state_d     = DONE;
                        quotient_d  = sign_q_q ? -q_final : q_final;
                        remainder_d = sign_r_q ? -r_final : r_final;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: working registers are reset too, so no X reaches the datapath.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sign_q_q    <= 1'b0;
            sign_r_q    <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            sign_q_q    <= sign_q_d;
            sign_r_q    <= sign_r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
        end
    end

    assign busy_o      = (state_q == BUSY) | accept;
    assign ready_o     = (state_q == DONE);
    assign quotient_o  = quotient_q;
    assign remainder_o = remainder_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expectations, a monitor
// pops them on every ready_o pulse. Honours DIV_ZERO_FAST_EN for latency.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic        annul_i;
    logic        busy_o;
    logic        ready_o;
    logic [31:0] quotient_o;
    logic [31:0] remainder_o;

    div_unit #(.WIDTH(32)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .start_i     (start_i),
        .signed_i    (signed_i),
        .dividend_i  (dividend_i),
        .divisor_i   (divisor_i),
        .annul_i     (annul_i),
        .busy_o      (busy_o),
        .ready_o     (ready_o),
        .quotient_o  (quotient_o),
        .remainder_o (remainder_o)
    );

    always #5 clk = ~clk;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 33;
`endif

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          at;
        string       name;
    } exp_t;

    typedef struct {
        string       name;
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    vec_t vecs[7] = '{
        '{"div_m7_2",     1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF},
        '{"div_7_m2",     1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001},
        '{"div_min_m1",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000},
        '{"divu_min_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
        '{"divu_5_0",     1'b0, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0005},
        '{"div_m5_0",     1'b1, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFB},
        '{"div_m100_m7",  1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'h0000_000E, 32'hFFFF_FFFE}
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (resetn === 1'b1 && ready_o === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: ready_o=1 at cycle %0d, expected 0", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_q"}, quotient_o, e.q);
                check({e.name, "_r"}, remainder_o, e.r);
                check({e.name, "_ready_cycle"}, 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; leaves start_i low one edge later.
    task automatic issue(input string name, input logic s, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eq,
                         input logic [31:0] er, input int lat, input bit expect_rdy);
        start_i    = 1'b1;
        signed_i   = s;
        dividend_i = a;
        divisor_i  = b;
        if (expect_rdy) sb.push_back('{eq, er, cyc + lat, name});
        #1;
        check({name, "_busy_accept"}, 32'(busy_o), 32'd1);
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            tick(1);
            k++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: %0d results pending, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn     = 1'b0;
        start_i    = 1'b0;
        signed_i   = 1'b0;
        dividend_i = '0;
        divisor_i  = '0;
        annul_i    = 1'b0;
        #12;
        check("reset_quotient", quotient_o, 32'd0);
        check("reset_remainder", remainder_o, 32'd0);
        check("reset_ready", 32'(ready_o), 32'd0);
        check("reset_busy", 32'(busy_o), 32'd0);
        tick(1);
        resetn = 1'b1;
        tick(2);

        // DIVU 100/7 with busy_o traced through every BUSY cycle.
        issue("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b1);
        for (int i = 1; i <= 32; i++) begin
            check($sformatf("busy_cycle_%0d", i), 32'(busy_o), 32'd1);
            tick(1);
        end
        check("busy_in_done", 32'(busy_o), 32'd0);
        check("ready_in_done", 32'(ready_o), 32'd1);
        wait_drain("divu_100_7");

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
                  (vecs[i].b == 32'd0) ? ZLAT : 33, 1'b1);
            wait_drain(vecs[i].name);
        end

        // Annul in BUSY cycle 10: no result, outputs keep -100/-7 result.
        issue("annul_victim", 1'b0, 32'd1000, 32'd10, 32'd0, 32'd0, 33, 1'b0);
        tick(9);
        annul_i = 1'b1;
        tick(1);
        annul_i = 1'b0;
        check("annul_busy", 32'(busy_o), 32'd0);
        check("annul_hold_q", quotient_o, 32'h0000_000E);
        check("annul_hold_r", remainder_o, 32'hFFFF_FFFE);
        tick(1);
        issue("after_annul", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 33, 1'b1);
        wait_drain("after_annul");

        // Start together with annul is ignored.
        start_i    = 1'b1;
        annul_i    = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd9;
        divisor_i  = 32'd3;
        #1;
        check("start_annul_busy", 32'(busy_o), 32'd0);
        tick(1);
        start_i = 1'b0;
        annul_i = 1'b0;
        check("start_annul_idle", 32'(busy_o), 32'd0);
        tick(40);
        check("start_annul_hold_q", quotient_o, 32'd100);

        // Back-to-back: second accept in the DONE cycle of the first.
        issue("b2b_first", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33, 1'b1);
        n = cyc - 1;
        for (int k = 0; k < 40 && cyc != n + 33; k++) tick(1);
        check("b2b_done_cycle", 32'(cyc), 32'(n + 33));
        issue("b2b_second", 1'b1, 32'hFFFF_FC18, 32'd3, 32'hFFFF_FEB3, 32'hFFFF_FFFF, 33, 1'b1);
        wait_drain("b2b");

        // Asynchronous reset in the middle of BUSY.
        issue("rst_victim", 1'b0, 32'd50, 32'd5, 32'd0, 32'd0, 33, 1'b0);
        tick(5);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_quotient", quotient_o, 32'd0);
        check("midrst_remainder", remainder_o, 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        tick(2);
        resetn = 1'b1;
        tick(1);
        check("postrst_busy", 32'(busy_o), 32'd0);
        issue("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33, 1'b1);
        wait_drain("divu_max_1");

        tick(3);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
